// File: rtl/sd_init_pkg.sv
// -----------------------------------------------------------------------------
// sd_init_pkg
// Shared definitions for the SD card initialization sequencer:
//   - state_t  : top-level sequencer states
//   - phase_t  : sub-phase of every command state (issue / wait / check)
//   - command index constants for the commands used during init
//   - fixed command arguments for CMD8 and ACMD41
//   - error codes reported on errcode when the sequence ends in FAIL
// -----------------------------------------------------------------------------
package sd_init_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_PWRUP  = 4'd1,
        ST_CMD0   = 4'd2,
        ST_CMD8   = 4'd3,
        ST_CMD55  = 4'd4,
        ST_ACMD41 = 4'd5,
        ST_CMD2   = 4'd6,
        ST_CMD3   = 4'd7,
        ST_DONE   = 4'd8,
        ST_FAIL   = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        PH_ISSUE = 2'd0,
        PH_WAIT  = 2'd1,
        PH_CHECK = 2'd2
    } phase_t;

    // Command indices
    localparam logic [5:0] CMD_IDX_GO_IDLE    = 6'd0;
    localparam logic [5:0] CMD_IDX_SEND_IF    = 6'd8;
    localparam logic [5:0] CMD_IDX_APP_CMD    = 6'd55;
    localparam logic [5:0] CMD_IDX_SD_OP_COND = 6'd41;
    localparam logic [5:0] CMD_IDX_ALL_CID    = 6'd2;
    localparam logic [5:0] CMD_IDX_SEND_RCA   = 6'd3;

    // CMD8: 2.7-3.6V supply range, check pattern 0xAA
    localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;
    // ACMD41: HCS=1, full voltage window
    localparam logic [31:0] ACMD41_ARG = 32'h40FF_8000;

    // Error codes (0 means no error)
    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_CMD8_RSP   = 3'd1;
    localparam logic [2:0] ERR_CMD8_VRNG  = 3'd2;
    localparam logic [2:0] ERR_CMD8_LAST  = 3'd3;
    localparam logic [2:0] ERR_CMD55_RSP  = 3'd4;
    localparam logic [2:0] ERR_ACMD41_TO  = 3'd5;
    localparam logic [2:0] ERR_CMD2_RSP   = 3'd6;
    localparam logic [2:0] ERR_CMD3_RSP   = 3'd7;

    // True for the states that run an issue/wait/check exchange
    function automatic logic is_cmd_state(input state_t s);
        case (s)
            ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD2, ST_CMD3: is_cmd_state = 1'b1;
            default:                                                  is_cmd_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sd_cmd_rom.sv
// -----------------------------------------------------------------------------
// sd_cmd_rom
// Combinational lookup from sequencer state to the command descriptor that the
// transceiver needs. Non-command states return an all-zero descriptor.
// Ports:
//   state_i   : sequencer state
//   idx_o     : 6-bit command index
//   arg_o     : 32-bit command argument
//   rsplong_o : command expects a 136-bit response
//   rspnone_o : command expects no response
// -----------------------------------------------------------------------------
module sd_cmd_rom
    import sd_init_pkg::*;
(
    input  state_t      state_i,
    output logic [5:0]  idx_o,
    output logic [31:0] arg_o,
    output logic        rsplong_o,
    output logic        rspnone_o
);

    always_comb begin
        idx_o     = 6'd0;
        arg_o     = 32'd0;
        rsplong_o = 1'b0;
        rspnone_o = 1'b0;
        case (state_i)
            ST_CMD0: begin
                idx_o     = CMD_IDX_GO_IDLE;
                rspnone_o = 1'b1;
            end
            ST_CMD8: begin
                idx_o = CMD_IDX_SEND_IF;
                arg_o = CMD8_ARG;
            end
            ST_CMD55: begin
                idx_o = CMD_IDX_APP_CMD;
            end
            ST_ACMD41: begin
                idx_o = CMD_IDX_SD_OP_COND;
                arg_o = ACMD41_ARG;
            end
            ST_CMD2: begin
                idx_o     = CMD_IDX_ALL_CID;
                rsplong_o = 1'b1;
            end
            ST_CMD3: begin
                idx_o = CMD_IDX_SEND_RCA;
            end
            default: begin
                idx_o     = 6'd0;
                arg_o     = 32'd0;
                rsplong_o = 1'b0;
                rspnone_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sd_init_seq.sv
// -----------------------------------------------------------------------------
// sd_init_seq
// SD card initialization sequencer: power-up wait, CMD0, CMD8 (with bounded
// retry), CMD55/ACMD41 poll loop, CMD2, CMD3. Every command runs a
// one-cycle ISSUE, a WAIT until the transceiver reports completion, and a
// one-cycle CHECK that decides the next step. All outputs are registered.
// Parameters:
//   MAXRETRY      : CMD8 reissues allowed after a response error
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   start         : one-cycle request to begin (only honoured in IDLE)
//   pwuptmrstop, vrngeapply, lasterr, sdinitlzd, mstotout : status inputs
//   tcvcptdone    : transceiver exchange finished
//   rsperr        : response timeout/CRC error, valid with tcvcptdone
//   pwruptmren, crdvtgrngewe, lasterrwe, sdcapstwe, acmd41fstwe,
//   mstotmren, pubrcast : register-enable outputs
//   cmdstart      : one-cycle command issue pulse
//   cmdidx/cmdarg/rsplong/rspnone : command descriptor, held per command
//   busy, done, fail, errcode     : sequencer status
// -----------------------------------------------------------------------------
module sd_init_seq
    import sd_init_pkg::*;
#(
    parameter int MAXRETRY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pwuptmrstop,
    input  logic        vrngeapply,
    input  logic        lasterr,
    input  logic        sdinitlzd,
    input  logic        mstotout,
    input  logic        tcvcptdone,
    input  logic        rsperr,
    output logic        pwruptmren,
    output logic        crdvtgrngewe,
    output logic        lasterrwe,
    output logic        sdcapstwe,
    output logic        acmd41fstwe,
    output logic        mstotmren,
    output logic        pubrcast,
    output logic        cmdstart,
    output logic [5:0]  cmdidx,
    output logic [31:0] cmdarg,
    output logic        rsplong,
    output logic        rspnone,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [2:0]  errcode
);

    // A zero MAXRETRY still needs a 1-bit counter to be legal
    localparam int RW = (MAXRETRY > 0) ? $clog2(MAXRETRY + 1) : 1;
    localparam logic [RW-1:0] RMAX = RW'(MAXRETRY);

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [2:0]    errcode_q, errcode_d;
    logic          rsperr_q, rsperr_d;
    logic          first_q;
    logic          enter_acmd41_check;

    logic          pwruptmren_q, crdvtgrngewe_q, lasterrwe_q, sdcapstwe_q;
    logic          acmd41fstwe_q, mstotmren_q, pubrcast_q, cmdstart_q;
    logic [5:0]    cmdidx_q;
    logic [31:0]   cmdarg_q;
    logic          rsplong_q, rspnone_q, busy_q, done_q, fail_q;

    logic [5:0]    rom_idx;
    logic [31:0]   rom_arg;
    logic          rom_long, rom_none;

    // The descriptor is looked up for the next state so that the registered
    // outputs line up with the state register.
    sd_cmd_rom u_rom (
        .state_i   (state_d),
        .idx_o     (rom_idx),
        .arg_o     (rom_arg),
        .rsplong_o (rom_long),
        .rspnone_o (rom_none)
    );

    assign enter_acmd41_check = (state_q == ST_ACMD41) && (phase_q == PH_WAIT) && tcvcptdone;

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        retry_d   = retry_q;
        errcode_d = errcode_q;
        rsperr_d  = rsperr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PWRUP;
                    phase_d = PH_ISSUE;
                end
            end
            ST_PWRUP: begin
                if (pwuptmrstop) begin
                    state_d = ST_CMD0;
                    phase_d = PH_ISSUE;
                end
            end
            ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD2, ST_CMD3: begin
                case (phase_q)
                    PH_ISSUE: phase_d = PH_WAIT;
                    PH_WAIT: begin
                        // rsperr is only meaningful alongside tcvcptdone, so
                        // capture it for the CHECK cycle.
                        if (tcvcptdone) begin
                            phase_d  = PH_CHECK;
                            rsperr_d = rsperr;
                        end
                    end
                    default: begin
                        phase_d = PH_ISSUE;
                        case (state_q)
                            ST_CMD0: begin
                                state_d = ST_CMD8;
                                retry_d = '0;
                            end
                            ST_CMD8: begin
                                if (rsperr_q) begin
                                    if (retry_q < RMAX) begin
                                        retry_d = retry_q + RW'(1);
                                    end else begin
                                        state_d   = ST_FAIL;
                                        errcode_d = ERR_CMD8_RSP;
                                    end
                                end else if (!vrngeapply) begin
                                    state_d   = ST_FAIL;
                                    errcode_d = ERR_CMD8_VRNG;
                                end else if (lasterr) begin
                                    state_d   = ST_FAIL;
                                    errcode_d = ERR_CMD8_LAST;
                                end else begin
                                    state_d = ST_CMD55;
                                end
                            end
                            ST_CMD55: begin
                                if (rsperr_q) begin
                                    state_d   = ST_FAIL;
                                    errcode_d = ERR_CMD55_RSP;
                                end else begin
                                    state_d = ST_ACMD41;
                                end
                            end
                            ST_ACMD41: begin
                                if (sdinitlzd) begin
                                    state_d = ST_CMD2;
                                end else if (mstotout) begin
                                    state_d   = ST_FAIL;
                                    errcode_d = ERR_ACMD41_TO;
                                end else begin
                                    state_d = ST_CMD55;
                                end
                            end
                            ST_CMD2: begin
                                if (rsperr_q) begin
                                    state_d   = ST_FAIL;
                                    errcode_d = ERR_CMD2_RSP;
                                end else begin
                                    state_d = ST_CMD3;
                                end
                            end
                            ST_CMD3: begin
                                if (rsperr_q) begin
                                    state_d   = ST_FAIL;
                                    errcode_d = ERR_CMD3_RSP;
                                end else begin
                                    state_d = ST_DONE;
                                end
                            end
                            default: begin
                                state_d = ST_IDLE;
                            end
                        endcase
                    end
                endcase
            end
            ST_DONE, ST_FAIL: begin
                // Terminal until reset
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = PH_ISSUE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            phase_q        <= PH_ISSUE;
            retry_q        <= '0;
            errcode_q      <= ERR_NONE;
            rsperr_q       <= 1'b0;
            first_q        <= 1'b1;
            pwruptmren_q   <= 1'b0;
            crdvtgrngewe_q <= 1'b0;
            lasterrwe_q    <= 1'b0;
            sdcapstwe_q    <= 1'b0;
            acmd41fstwe_q  <= 1'b0;
            mstotmren_q    <= 1'b0;
            pubrcast_q     <= 1'b0;
            cmdstart_q     <= 1'b0;
            cmdidx_q       <= 6'd0;
            cmdarg_q       <= 32'd0;
            rsplong_q      <= 1'b0;
            rspnone_q      <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            fail_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            retry_q        <= retry_d;
            errcode_q      <= errcode_d;
            rsperr_q       <= rsperr_d;
            // acmd41fstwe fires only on the first ACMD41 CHECK since reset
            if (enter_acmd41_check) begin
                first_q <= 1'b0;
            end
            acmd41fstwe_q  <= enter_acmd41_check && first_q;
            pwruptmren_q   <= (state_d == ST_PWRUP);
            crdvtgrngewe_q <= (state_d == ST_CMD8)   && (phase_d == PH_WAIT);
            lasterrwe_q    <= (state_d == ST_CMD8)   && (phase_d == PH_WAIT);
            sdcapstwe_q    <= (state_d == ST_ACMD41) && (phase_d == PH_WAIT);
            mstotmren_q    <= (state_d == ST_ACMD41) && (phase_d == PH_WAIT);
            pubrcast_q     <= (state_d == ST_CMD3)   && (phase_d == PH_WAIT);
            cmdstart_q     <= is_cmd_state(state_d)  && (phase_d == PH_ISSUE);
            cmdidx_q       <= rom_idx;
            cmdarg_q       <= rom_arg;
            rsplong_q      <= rom_long;
            rspnone_q      <= rom_none;
            busy_q         <= !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_FAIL));
            done_q         <= (state_d == ST_DONE);
            fail_q         <= (state_d == ST_FAIL);
        end
    end

    assign pwruptmren   = pwruptmren_q;
    assign crdvtgrngewe = crdvtgrngewe_q;
    assign lasterrwe    = lasterrwe_q;
    assign sdcapstwe    = sdcapstwe_q;
    assign acmd41fstwe  = acmd41fstwe_q;
    assign mstotmren    = mstotmren_q;
    assign pubrcast     = pubrcast_q;
    assign cmdstart     = cmdstart_q;
    assign cmdidx       = cmdidx_q;
    assign cmdarg       = cmdarg_q;
    assign rsplong      = rsplong_q;
    assign rspnone      = rspnone_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign fail         = fail_q;
    assign errcode      = errcode_q;

endmodule

// File: tb/tb_sd_init_seq.sv
// -----------------------------------------------------------------------------
// tb_sd_init_seq
// Directed bench for sd_init_seq: nominal init, CMD8 retry boundary and
// exhaustion, CMD8 status failures, CMD55 response error, ACMD41 timeout,
// and reset in the middle of an ACMD41 exchange.
// -----------------------------------------------------------------------------
module tb_sd_init_seq;

    logic        clk = 1'b0;
    logic        reset, start, pwuptmrstop, vrngeapply, lasterr, sdinitlzd, mstotout;
    logic        tcvcptdone, rsperr;
    logic        pwruptmren, crdvtgrngewe, lasterrwe, sdcapstwe, acmd41fstwe, mstotmren, pubrcast;
    logic        cmdstart, rsplong, rspnone, busy, done, fail;
    logic [5:0]  cmdidx;
    logic [31:0] cmdarg;
    logic [2:0]  errcode;

    int total = 0;
    int bad   = 0;

    // Command/pulse log, cleared while reset is held
    logic [5:0] cmdlog [0:63];
    int         ncmd   = 0;
    int         npulse = 0;

    // Values seen during the WAIT phase of the last exchange
    logic w_crd, w_lerr, w_sdcap, w_mstot, w_pub, w_long, w_none, w_start;
    logic [31:0] w_arg;

    logic [5:0] exp_nom [0:9];

    always #5 clk = ~clk;

    sd_init_seq #(.MAXRETRY(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .pwuptmrstop  (pwuptmrstop),
        .vrngeapply   (vrngeapply),
        .lasterr      (lasterr),
        .sdinitlzd    (sdinitlzd),
        .mstotout     (mstotout),
        .tcvcptdone   (tcvcptdone),
        .rsperr       (rsperr),
        .pwruptmren   (pwruptmren),
        .crdvtgrngewe (crdvtgrngewe),
        .lasterrwe    (lasterrwe),
        .sdcapstwe    (sdcapstwe),
        .acmd41fstwe  (acmd41fstwe),
        .mstotmren    (mstotmren),
        .pubrcast     (pubrcast),
        .cmdstart     (cmdstart),
        .cmdidx       (cmdidx),
        .cmdarg       (cmdarg),
        .rsplong      (rsplong),
        .rspnone      (rspnone),
        .busy         (busy),
        .done         (done),
        .fail         (fail),
        .errcode      (errcode)
    );

    always @(negedge clk) begin
        if (reset) begin
            ncmd   <= 0;
            npulse <= 0;
        end else begin
            if (cmdstart === 1'b1 && ncmd < 64) begin
                cmdlog[ncmd] <= cmdidx;
                ncmd         <= ncmd + 1;
            end
            if (acmd41fstwe === 1'b1) npulse <= npulse + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0; pwuptmrstop = 1'b0; tcvcptdone = 1'b0; rsperr = 1'b0;
        vrngeapply = 1'b1; lasterr = 1'b0; sdinitlzd = 1'b0; mstotout = 1'b0;
        #1;
        chk("rst_busy",   32'(busy), 0);
        chk("rst_start",  32'(cmdstart), 0);
        chk("rst_idx",    32'(cmdidx), 0);
        chk("rst_arg",    cmdarg, 0);
        chk("rst_err",    32'(errcode), 0);
        chk("rst_donefl", 32'({done, fail}), 0);
        step();
        step();
        reset = 1'b0;
    endtask

    // start pulse, one PWRUP cycle, then land in CMD0 ISSUE
    task automatic boot();
        start = 1'b1;
        step();
        start = 1'b0;
        pwuptmrstop = 1'b1;
        step();
        pwuptmrstop = 1'b0;
    endtask

    task automatic wait_issue(input logic [5:0] idx, input string tag);
        int n = 0;
        while (cmdstart !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk({tag, "_issue"}, 32'(cmdstart), 1);
        chk({tag, "_idx"},   32'(cmdidx), 32'(idx));
    endtask

    task automatic xchg(input logic [5:0] idx, input logic err, input string tag);
        wait_issue(idx, tag);
        step();
        w_crd = crdvtgrngewe; w_lerr = lasterrwe; w_sdcap = sdcapstwe;
        w_mstot = mstotmren;  w_pub = pubrcast;   w_long = rsplong;
        w_none = rspnone;     w_start = cmdstart; w_arg = cmdarg;
        step();
        chk({tag, "_stable"}, 32'(cmdidx), 32'(idx));
        tcvcptdone = 1'b1;
        rsperr     = err;
        step();
        tcvcptdone = 1'b0;
        rsperr     = 1'b0;
        step();
    endtask

    initial begin
        exp_nom = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd2, 6'd3};

        // ---------------- nominal sequence ----------------
        do_reset();
        step();
        chk("idle_nostart", 32'(cmdstart), 0);
        chk("idle_busy",    32'(busy), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("pwrup_busy", 32'(busy), 1);
        chk("pwrup_tmr",  32'(pwruptmren), 1);
        for (int i = 0; i < 9; i++) step();
        chk("pwrup_tmr_hold", 32'(pwruptmren), 1);
        pwuptmrstop = 1'b1;
        step();
        pwuptmrstop = 1'b0;
        chk("cmd0_tmr_off", 32'(pwruptmren), 0);

        xchg(6'd0, 1'b0, "n_cmd0");
        chk("cmd0_none",  32'(w_none), 1);
        chk("cmd0_crdwe", 32'(w_crd), 0);
        chk("cmd0_wstart",32'(w_start), 0);
        xchg(6'd8, 1'b0, "n_cmd8");
        chk("cmd8_crdwe", 32'(w_crd), 1);
        chk("cmd8_lerrwe",32'(w_lerr), 1);
        chk("cmd8_arg",   w_arg, 32'h0000_01AA);
        xchg(6'd55, 1'b0, "n_c55a");
        chk("cmd55_sdcap", 32'(w_sdcap), 0);
        xchg(6'd41, 1'b0, "n_a41a");
        chk("a41_sdcap", 32'(w_sdcap), 1);
        chk("a41_mstot", 32'(w_mstot), 1);
        chk("a41_arg",   w_arg, 32'h40FF_8000);
        xchg(6'd55, 1'b0, "n_c55b");
        xchg(6'd41, 1'b0, "n_a41b");
        xchg(6'd55, 1'b0, "n_c55c");
        sdinitlzd = 1'b1;
        xchg(6'd41, 1'b0, "n_a41c");
        sdinitlzd = 1'b0;
        xchg(6'd2, 1'b0, "n_cmd2");
        chk("cmd2_long", 32'(w_long), 1);
        xchg(6'd3, 1'b0, "n_cmd3");
        chk("cmd3_pub",  32'(w_pub), 1);
        chk("cmd3_long", 32'(w_long), 0);
        chk("nom_done",  32'(done), 1);
        chk("nom_busy",  32'(busy), 0);
        chk("nom_ncmd",  ncmd, 10);
        for (int i = 0; i < 10; i++) chk("nom_seq", 32'(cmdlog[i]), 32'(exp_nom[i]));
        chk("nom_fstwe", npulse, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("done_hold", 32'({done, busy, cmdstart}), 32'b100);

        // ---------------- CMD8 three errors then clean ----------------
        do_reset();
        boot();
        xchg(6'd0, 1'b0, "r_cmd0");
        for (int i = 0; i < 3; i++) xchg(6'd8, 1'b1, "r_cmd8e");
        xchg(6'd8, 1'b0, "r_cmd8ok");
        wait_issue(6'd55, "r_cmd55");
        chk("r_nofail", 32'(fail), 0);

        // ---------------- CMD8 retries exhausted ----------------
        do_reset();
        boot();
        xchg(6'd0, 1'b0, "x_cmd0");
        for (int i = 0; i < 4; i++) xchg(6'd8, 1'b1, "x_cmd8");
        chk("x_fail", 32'(fail), 1);
        chk("x_code", 32'(errcode), 1);
        chk("x_busy", 32'(busy), 0);
        step();
        chk("x_ncmd", ncmd, 5);
        for (int i = 1; i < 5; i++) chk("x_seq8", 32'(cmdlog[i]), 8);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("fail_hold", 32'({fail, busy, errcode}), 32'b1_0_001);

        // ---------------- CMD8 voltage range rejected ----------------
        do_reset();
        vrngeapply = 1'b0;
        boot();
        xchg(6'd0, 1'b0, "v_cmd0");
        xchg(6'd8, 1'b0, "v_cmd8");
        chk("v_fail", 32'(fail), 1);
        chk("v_code", 32'(errcode), 2);

        // ---------------- CMD8 lasterr ----------------
        do_reset();
        lasterr = 1'b1;
        boot();
        xchg(6'd0, 1'b0, "l_cmd0");
        xchg(6'd8, 1'b0, "l_cmd8");
        chk("l_fail", 32'(fail), 1);
        chk("l_code", 32'(errcode), 3);

        // ---------------- CMD55 response error ----------------
        do_reset();
        boot();
        xchg(6'd0, 1'b0, "a_cmd0");
        xchg(6'd8, 1'b0, "a_cmd8");
        xchg(6'd55, 1'b1, "a_cmd55");
        chk("a_code", 32'(errcode), 4);

        // ---------------- ACMD41 timeout ----------------
        do_reset();
        boot();
        xchg(6'd0, 1'b0, "t_cmd0");
        xchg(6'd8, 1'b0, "t_cmd8");
        for (int i = 0; i < 4; i++) begin
            xchg(6'd55, 1'b0, "t_c55");
            xchg(6'd41, 1'b0, "t_a41");
        end
        xchg(6'd55, 1'b0, "t_c55l");
        mstotout = 1'b1;
        xchg(6'd41, 1'b0, "t_a41l");
        mstotout = 1'b0;
        step();
        chk("t_fail", 32'(fail), 1);
        chk("t_code", 32'(errcode), 5);
        chk("t_ncmd", ncmd, 12);
        chk("t_last", 32'(cmdlog[11]), 41);

        // ---------------- reset during ACMD41 WAIT ----------------
        do_reset();
        boot();
        xchg(6'd0, 1'b0, "m_cmd0");
        xchg(6'd8, 1'b0, "m_cmd8");
        xchg(6'd55, 1'b0, "m_cmd55");
        wait_issue(6'd41, "m_a41");
        step();
        chk("m_inwait", 32'(sdcapstwe), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("m_busy",  32'(busy), 0);
        chk("m_ens",   32'({sdcapstwe, mstotmren, crdvtgrngewe, lasterrwe, pubrcast, pwruptmren, acmd41fstwe}), 0);
        chk("m_idx",   32'(cmdidx), 0);
        chk("m_arg",   cmdarg, 0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("m_idle", 32'({busy, cmdstart}), 0);
        sdinitlzd = 1'b1;
        boot();
        xchg(6'd0, 1'b0, "m2_cmd0");
        xchg(6'd8, 1'b0, "m2_cmd8");
        xchg(6'd55, 1'b0, "m2_cmd55");
        xchg(6'd41, 1'b0, "m2_a41");
        xchg(6'd2, 1'b0, "m2_cmd2");
        xchg(6'd3, 1'b0, "m2_cmd3");
        chk("m2_done",  32'(done), 1);
        chk("m2_fstwe", npulse, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_init_seq.md
SD_INIT_SEQ -- requirements
Module: sd_init_seq

Interface
REQ-001 SHALL have parameter MAXRETRY, default 3, meaning CMD8 reissues allowed after a response error.
REQ-002 SHALL have port clk  in  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  in  1  one-cycle request to begin card initialization; honoured only in IDLE.
REQ-005 SHALL have status inputs (each 1 bit): pwuptmrstop, vrngeapply, lasterr, sdinitlzd, mstotout (from the init status register block).
REQ-006 SHALL have transceiver inputs (each 1 bit): tcvcptdone = command/response packet finished; rsperr = response timeout or CRC fail, valid with tcvcptdone.
REQ-007 SHALL have register-enable outputs (each 1 bit): pwruptmren, crdvtgrngewe, lasterrwe, sdcapstwe, acmd41fstwe, mstotmren, pubrcast.
REQ-008 SHALL have transceiver outputs: cmdstart out 1 (one-cycle issue pulse); cmdidx out 6; cmdarg out 32; rsplong out 1 (136-bit response); rspnone out 1 (no response).
REQ-009 SHALL have outputs busy, done, fail (each 1 bit) and errcode out 3.

Function
REQ-010 SHALL implement states IDLE, PWRUP, CMD0, CMD8, CMD55, ACMD41, CMD2, CMD3, DONE, FAIL; each CMDx state has phases ISSUE, WAIT, CHECK.
REQ-011 ISSUE SHALL last exactly one cycle with cmdstart=1; WAIT SHALL hold until tcvcptdone=1; CHECK SHALL last one cycle and evaluate status inputs.
REQ-012 cmdidx/cmdarg/rsplong/rspnone SHALL be stable from ISSUE through CHECK; tcvcptdone outside WAIT SHALL be ignored.
REQ-013 IDLE: start=1 -> PWRUP; busy=0 only in IDLE, DONE, FAIL.
REQ-014 PWRUP: pwruptmren=1 every cycle; pwuptmrstop=1 -> CMD0.
REQ-015 CMD0: idx 0, arg 0, rspnone=1; rsperr ignored; CHECK -> CMD8.
REQ-016 CMD8: idx 8, arg 32'h000001AA; crdvtgrngewe=lasterrwe=1 during WAIT. CHECK: rsperr and retries<MAXRETRY -> reissue CMD8 (retry count +1); rsperr and retries==MAXRETRY -> FAIL code 1; vrngeapply=0 -> FAIL code 2; lasterr=1 -> FAIL code 3; else -> CMD55.
REQ-017 CMD55: idx 55, arg 0; CHECK: rsperr -> FAIL code 4, else -> ACMD41.
REQ-018 ACMD41: idx 41, arg 32'h40FF8000; sdcapstwe=mstotmren=1 during WAIT; acmd41fstwe=1 for one cycle on the first ACMD41 CHECK after reset only.
REQ-019 ACMD41 CHECK priority: sdinitlzd=1 -> CMD2; else mstotout=1 -> FAIL code 5; else -> CMD55 (poll loop, no limit besides mstotout).
REQ-020 CMD2: idx 2, arg 0, rsplong=1; CHECK: rsperr -> FAIL code 6, else -> CMD3.
REQ-021 CMD3: idx 3, arg 0; pubrcast=1 during WAIT; CHECK: rsperr -> FAIL code 7, else -> DONE.
REQ-022 DONE holds done=1, FAIL holds fail=1 and errcode until reset; start ignored in both.
REQ-023 All register-enable outputs SHALL be 0 outside the states/phases listed above.
REQ-024 Retry counter SHALL be clog2(MAXRETRY+1) bits, cleared on entry to CMD8 from CMD0; never wraps.

Reset
REQ-025 reset=1 SHALL force IDLE immediately, mid-operation included, with all outputs 0, cmdidx=0, cmdarg=0, errcode=0, retry counter 0, ACMD41-first flag set.
REQ-026 On reset release, first rising clk edge SHALL see IDLE; no cmdstart before start.

Structure
REQ-027 Package sd_init_pkg SHALL hold state/phase enums, command index constants, CMD8/ACMD41 argument constants, errcode values 1..7.
REQ-028 Sub-module sd_cmd_rom (combinational: state -> idx, arg, rsplong, rspnone) SHALL be used.

Verification
REQ-029 Nominal: start, pwuptmrstop after 10 cycles, responses clean, vrngeapply=1, sdinitlzd=1 on 3rd ACMD41 -> cmdidx sequence 0,8,55,41,55,41,55,41,2,3; done=1; acmd41fstwe pulsed once.
REQ-030 CMD8 rsperr on 4 consecutive exchanges (MAXRETRY=3) -> four CMD8 issues, fail=1, errcode=1.
REQ-031 CMD8 clean but vrngeapply=0 -> fail=1, errcode=2; with vrngeapply=1, lasterr=1 -> errcode=3.
REQ-032 sdinitlzd never set, mstotout raised after 5th ACMD41 -> fail=1, errcode=5, no CMD2 issued.
REQ-033 reset asserted during ACMD41 WAIT -> same cycle busy=0, all enables 0; new start reruns from PWRUP with acmd41fstwe pulsed again.
